// File: rtl/debounce_pkg.sv
// Shared types and helpers for the shared-timer debounce scheduler.
package debounce_pkg;

  // Scheduler FSM: wait for a pending channel, time its stability, commit it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_rr_arbiter.sv
// Round-robin selector: picks the first requesting channel after 'pointer',
// wrapping around, so the channel served last has the lowest priority.
module debounce_rr_arbiter
  import debounce_pkg::*;
#(
  parameter int  NUM_CHANNELS = 4,
  localparam int CHW          = chan_width(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] request,
  input  logic [CHW-1:0]          pointer,
  output logic [CHW-1:0]          grant,
  output logic                    any_request
);

  // Scan from farthest to nearest offset so the nearest requester wins last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    grant       = '0;
    any_request = |request;
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      if (request[(int'(pointer) + k) % NUM_CHANNELS]) begin
        grant = CHW'((int'(pointer) + k) % NUM_CHANNELS);
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounces NUM_CHANNELS raw inputs with one shared stability timer. A
// round-robin arbiter lends the timer to a channel whose synchronized level
// disagrees with its debounced level; the level is committed once it has been
// stable for D+1 timed cycles, and a one-cycle change event is emitted.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int  NUM_CHANNELS           = 4,
  parameter int  DEBOUNCE_COUNTER_WIDTH = 24,
  localparam int CHW                    = chan_width(NUM_CHANNELS)
) (
  input  logic                              i_clock,
  input  logic                              i_reset_n,
  input  logic [DEBOUNCE_COUNTER_WIDTH-1:0] i_debounce_counter,
  input  logic [NUM_CHANNELS-1:0]           i_bouncing_signal,
  output logic [NUM_CHANNELS-1:0]           o_debounced_signal,
  output logic                              o_event_valid,
  output logic [CHW-1:0]                    o_event_channel,
  output logic                              o_event_level,
  output logic                              o_busy
);

  localparam int DCW = DEBOUNCE_COUNTER_WIDTH;

  // Channel 0 must have first priority out of reset, so the pointer starts
  // at the last channel.
  localparam logic [CHW-1:0] POINTER_RESET = CHW'(NUM_CHANNELS - 1);

  // Synchronizer stages.
  logic [NUM_CHANNELS-1:0] sync_meta;
  logic [NUM_CHANNELS-1:0] sync_level;

  // Channels whose settled input disagrees with their debounced level.
  logic [NUM_CHANNELS-1:0] pending;

  // Arbiter result.
  logic [CHW-1:0] arb_grant;
  logic           arb_any;

  // FSM and shared timer.
  state_e         state;
  state_e         state_next;
  logic [DCW-1:0] timer;
  logic [DCW-1:0] period;
  logic [CHW-1:0] grant;
  logic [CHW-1:0] pointer;

  // Granted channel's view, used by the FSM and the commit path.
  logic granted_sync;
  logic granted_level;

  // Datapath strobes decoded by the FSM.
  logic load_grant;
  logic advance_timer;
  logic abort_grant;
  logic commit_grant;

  // Two-flop synchronizer per channel; only sync_level is used downstream.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments and an async
    // active-low reset; the synchronizer flops are reset too so no stale
    // level reaches the pending logic after reset release.
    if (!i_reset_n) begin
      sync_meta  <= '0;
      sync_level <= '0;
    end else begin
      sync_meta  <= i_bouncing_signal;
      sync_level <= sync_meta;
    end
  end

  assign pending       = sync_level ^ o_debounced_signal;
  assign granted_sync  = sync_level[grant];
  assign granted_level = o_debounced_signal[grant];
  assign o_busy        = (state != IDLE);

  debounce_rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_arbiter (
    .request     (pending),
    .pointer     (pointer),
    .grant       (arb_grant),
    .any_request (arb_any)
  );

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobe decode.
  always_comb begin
    state_next    = state;
    load_grant    = 1'b0;
    advance_timer = 1'b0;
    abort_grant   = 1'b0;
    commit_grant  = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_any) begin
          load_grant = 1'b1;
          state_next = TIMING;
        end
      end
      TIMING: begin
        if (granted_sync == granted_level) begin
          // The input bounced back before the period elapsed.
          abort_grant = 1'b1;
          state_next  = IDLE;
        end else if (timer == period) begin
          // Equality against the latched period means the timer never wraps.
          state_next = COMMIT;
        end else begin
          advance_timer = 1'b1;
        end
      end
      COMMIT: begin
        commit_grant = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Timer, latched grant/period and round-robin pointer.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      timer   <= '0;
      period  <= '0;
      grant   <= '0;
      pointer <= POINTER_RESET;
    end else begin
      if (load_grant) begin
        grant  <= arb_grant;
        period <= i_debounce_counter;
        timer  <= '0;
      end
      if (advance_timer) begin
        timer <= timer + DCW'(1);
      end
      // Advancing on abort as well keeps a chattering channel from
      // monopolising the timer.
      if (abort_grant || commit_grant) begin
        pointer <= grant;
      end
    end
  end

  // Debounced levels and the registered change event.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_debounced_signal <= '0;
      o_event_valid      <= 1'b0;
      o_event_channel    <= '0;
      o_event_level      <= 1'b0;
    end else begin
      o_event_valid <= 1'b0;
      if (commit_grant) begin
        o_debounced_signal[grant] <= granted_sync;
        o_event_valid             <= 1'b1;
        o_event_channel           <= grant;
        o_event_level             <= granted_sync;
      end
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with 4 channels and a 4-bit timer.
// Inputs change just after a falling edge; outputs are sampled 1 time unit
// after each rising edge. Edge counts start at the first rising edge that
// samples the new input level.
module tb_debounce_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] debounce_counter;
  logic [3:0] bouncing;
  logic [3:0] debounced;
  logic       event_valid;
  logic [1:0] event_channel;
  logic       event_level;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int busy_cycles = 0;

  debounce_scheduler #(
    .NUM_CHANNELS           (4),
    .DEBOUNCE_COUNTER_WIDTH (4)
  ) dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_debounce_counter (debounce_counter),
    .i_bouncing_signal  (bouncing),
    .o_debounced_signal (debounced),
    .o_event_valid      (event_valid),
    .o_event_channel    (event_channel),
    .o_event_level      (event_level),
    .o_busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset with all inputs low, released just after a falling edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    bouncing = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts rising edges until an event is seen (cycles = -1 if none within
  // limit) and counts the samples in which busy was high.
  task automatic wait_event(input int limit, output int cycles);
    cycles      = -1;
    busy_cycles = 0;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cycles++;
      if (event_valid) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_n            = 1'b0;
    bouncing         = 4'b0000;
    debounce_counter = 4'd10;
    repeat (2) @(negedge clk);
    vectors++; if (debounced !== 4'b0000) begin miscompares++; $display("FAIL reset_debounced: got %b expected 0000", debounced); end
    vectors++; if (event_valid !== 1'b0) begin miscompares++; $display("FAIL reset_event_valid: got %b expected 0", event_valid); end
    vectors++; if (event_channel !== 2'd0) begin miscompares++; $display("FAIL reset_event_channel: got %0d expected 0", event_channel); end
    vectors++; if (event_level !== 1'b0) begin miscompares++; $display("FAIL reset_event_level: got %b expected 0", event_level); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_event(20, seen);
    vectors++; if (seen !== -1) begin miscompares++; $display("FAIL reset_quiet_event: got event at edge %0d expected none", seen); end
    vectors++; if (busy_cycles !== 0) begin miscompares++; $display("FAIL reset_quiet_busy: got %0d busy cycles expected 0", busy_cycles); end
  endtask

  task automatic test_clean_step();
    int seen;
    do_reset();
    debounce_counter = 4'd10;
    @(negedge clk);
    bouncing[2] = 1'b1;
    wait_event(40, seen);
    vectors++; if (seen !== 15) begin miscompares++; $display("FAIL step_rise_latency: got edge %0d expected 15", seen); end
    vectors++; if (event_channel !== 2'd2) begin miscompares++; $display("FAIL step_rise_channel: got %0d expected 2", event_channel); end
    vectors++; if (event_level !== 1'b1) begin miscompares++; $display("FAIL step_rise_level: got %b expected 1", event_level); end
    vectors++; if (debounced !== 4'b0100) begin miscompares++; $display("FAIL step_rise_debounced: got %b expected 0100", debounced); end
    vectors++; if (busy_cycles !== 12) begin miscompares++; $display("FAIL step_busy_cycles: got %0d expected 12", busy_cycles); end
    @(posedge clk);
    #1;
    vectors++; if (event_valid !== 1'b0) begin miscompares++; $display("FAIL step_pulse_width: got %b expected 0", event_valid); end
    vectors++; if (event_channel !== 2'd2) begin miscompares++; $display("FAIL step_channel_hold: got %0d expected 2", event_channel); end
    @(negedge clk);
    bouncing[2] = 1'b0;
    wait_event(40, seen);
    vectors++; if (seen !== 15) begin miscompares++; $display("FAIL step_fall_latency: got edge %0d expected 15", seen); end
    vectors++; if (event_level !== 1'b0) begin miscompares++; $display("FAIL step_fall_level: got %b expected 0", event_level); end
    vectors++; if (debounced !== 4'b0000) begin miscompares++; $display("FAIL step_fall_debounced: got %b expected 0000", debounced); end
  endtask

  task automatic test_abort();
    int seen;
    do_reset();
    debounce_counter = 4'd10;
    @(negedge clk);
    bouncing[1] = 1'b1;
    repeat (5) @(negedge clk);
    bouncing[1] = 1'b0;
    wait_event(30, seen);
    vectors++; if (seen !== -1) begin miscompares++; $display("FAIL abort_no_event: got event at edge %0d expected none", seen); end
    vectors++; if (debounced !== 4'b0000) begin miscompares++; $display("FAIL abort_debounced: got %b expected 0000", debounced); end
    // Pointer now rests on channel 1, so channel 2 outranks channel 0.
    @(negedge clk);
    bouncing = 4'b0101;
    wait_event(40, seen);
    vectors++; if (seen !== 15) begin miscompares++; $display("FAIL abort_next_latency: got edge %0d expected 15", seen); end
    vectors++; if (event_channel !== 2'd2) begin miscompares++; $display("FAIL abort_pointer_order: got channel %0d expected 2", event_channel); end
    wait_event(40, seen);
    vectors++; if (seen !== 13) begin miscompares++; $display("FAIL abort_second_latency: got edge %0d expected 13", seen); end
    vectors++; if (event_channel !== 2'd0) begin miscompares++; $display("FAIL abort_second_channel: got %0d expected 0", event_channel); end
  endtask

  task automatic test_contention();
    int seen;
    do_reset();
    debounce_counter = 4'd4;
    @(negedge clk);
    bouncing = 4'b1011;
    wait_event(40, seen);
    vectors++; if (seen !== 9) begin miscompares++; $display("FAIL contend_first_latency: got edge %0d expected 9", seen); end
    vectors++; if (event_channel !== 2'd0) begin miscompares++; $display("FAIL contend_first_channel: got %0d expected 0", event_channel); end
    wait_event(40, seen);
    vectors++; if (seen !== 7) begin miscompares++; $display("FAIL contend_second_spacing: got %0d cycles expected 7", seen); end
    vectors++; if (event_channel !== 2'd1) begin miscompares++; $display("FAIL contend_second_channel: got %0d expected 1", event_channel); end
    wait_event(40, seen);
    vectors++; if (seen !== 7) begin miscompares++; $display("FAIL contend_third_spacing: got %0d cycles expected 7", seen); end
    vectors++; if (event_channel !== 2'd3) begin miscompares++; $display("FAIL contend_third_channel: got %0d expected 3", event_channel); end
    vectors++; if (debounced !== 4'b1011) begin miscompares++; $display("FAIL contend_debounced: got %b expected 1011", debounced); end
  endtask

  task automatic test_chatter();
    int ch3_edge  = -1;
    int ch1_count = 0;
    do_reset();
    debounce_counter = 4'd4;
    @(negedge clk);
    bouncing = 4'b1010;
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          @(negedge clk);
          bouncing[1] = ~bouncing[1];
        end
      end
      begin
        for (int c = 1; c <= 40; c++) begin
          @(posedge clk);
          #1;
          if (event_valid && event_channel == 2'd3 && ch3_edge < 0) ch3_edge = c;
          if (event_valid && event_channel == 2'd1) ch1_count++;
        end
      end
    join
    vectors++; if (ch3_edge !== 11) begin miscompares++; $display("FAIL chatter_ch3_served: got edge %0d expected 11", ch3_edge); end
    vectors++; if (ch1_count !== 0) begin miscompares++; $display("FAIL chatter_ch1_events: got %0d expected 0", ch1_count); end
    vectors++; if (debounced[3] !== 1'b1) begin miscompares++; $display("FAIL chatter_ch3_level: got %b expected 1", debounced[3]); end
  endtask

  task automatic test_period_extremes();
    int seen;
    do_reset();
    debounce_counter = 4'd0;
    @(negedge clk);
    bouncing[0] = 1'b1;
    wait_event(40, seen);
    vectors++; if (seen !== 5) begin miscompares++; $display("FAIL d0_latency: got edge %0d expected 5", seen); end
    vectors++; if (debounced !== 4'b0001) begin miscompares++; $display("FAIL d0_debounced: got %b expected 0001", debounced); end
    debounce_counter = 4'd15;
    @(negedge clk);
    bouncing[1] = 1'b1;
    wait_event(60, seen);
    vectors++; if (seen !== 20) begin miscompares++; $display("FAIL dmax_latency: got edge %0d expected 20", seen); end
    vectors++; if (event_channel !== 2'd1) begin miscompares++; $display("FAIL dmax_channel: got %0d expected 1", event_channel); end
    vectors++; if (debounced !== 4'b0011) begin miscompares++; $display("FAIL dmax_debounced: got %b expected 0011", debounced); end
  endtask

  task automatic test_period_change();
    int seen;
    do_reset();
    debounce_counter = 4'd10;
    @(negedge clk);
    bouncing[2] = 1'b1;
    fork
      begin
        repeat (6) @(negedge clk);
        debounce_counter = 4'd3;
      end
      wait_event(40, seen);
    join
    vectors++; if (seen !== 15) begin miscompares++; $display("FAIL dchange_latched: got edge %0d expected 15", seen); end
    @(negedge clk);
    bouncing[2] = 1'b0;
    wait_event(40, seen);
    vectors++; if (seen !== 8) begin miscompares++; $display("FAIL dchange_next_grant: got edge %0d expected 8", seen); end
    vectors++; if (event_level !== 1'b0) begin miscompares++; $display("FAIL dchange_level: got %b expected 0", event_level); end
  endtask

  task automatic test_reset_mid_timing();
    int seen;
    int stray = 0;
    do_reset();
    debounce_counter = 4'd10;
    @(negedge clk);
    bouncing[3] = 1'b1;
    wait_event(40, seen);
    vectors++; if (debounced !== 4'b1000) begin miscompares++; $display("FAIL midrst_setup: got %b expected 1000", debounced); end
    @(negedge clk);
    bouncing[0] = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (debounced !== 4'b0000) begin miscompares++; $display("FAIL midrst_debounced: got %b expected 0000", debounced); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (event_valid) stray++;
    end
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL midrst_no_event: got %0d pulses expected 0", stray); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_event(40, seen);
    vectors++; if (seen !== 15) begin miscompares++; $display("FAIL midrst_rise_latency: got edge %0d expected 15", seen); end
    vectors++; if (event_channel !== 2'd0) begin miscompares++; $display("FAIL midrst_rise_channel: got %0d expected 0", event_channel); end
    wait_event(40, seen);
    vectors++; if (seen !== 13) begin miscompares++; $display("FAIL midrst_second_latency: got edge %0d expected 13", seen); end
    vectors++; if (debounced !== 4'b1001) begin miscompares++; $display("FAIL midrst_debounced_final: got %b expected 1001", debounced); end
  endtask

  initial begin
    rst_n            = 1'b0;
    bouncing         = 4'b0000;
    debounce_counter = 4'd10;
    test_reset();
    test_clean_step();
    test_abort();
    test_contention();
    test_chatter();
    test_period_extremes();
    test_period_change();
    test_reset_mid_timing();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
